// File: rtl/token_tx.sv
// Token packet transmitter: latches PID/address/endpoint, computes the CRC5
// over the 11 address+endpoint bits, then streams the 24-bit packet MSB first.
module token_tx #(
  parameter logic [4:0] CRC_INIT = 5'b00000
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic [7:0]  pid_in,
  input  logic [6:0]  addr_in,
  input  logic [3:0]  endp_in,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic [23:0] packet_out,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRC   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  crc_q;
  logic [4:0]  crc_d;
  logic [23:0] packet_q;
  logic        tok_ready_q;
  logic        tx_valid_q;
  logic        tx_bit_q;
  logic        done_q;

  logic [10:0] crcWindow;
  logic [23:0] txWindow;
  logic        feedback;

  // Shifting by the counter keeps the selected bit at a fixed index,
  // so counter values outside the active state never index out of range.
  always_comb begin
    crcWindow = packet_q[15:5] << cnt_q;
    txWindow  = packet_q << cnt_q;
    feedback  = crc_q[4] ^ crcWindow[10];
    crc_d     = {crc_q[3:0], 1'b0} ^ (feedback ? 5'b00101 : 5'b00000);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      crc_q       <= 5'd0;
      packet_q    <= 24'h0;
      tok_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_bit_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tok_valid) begin
            packet_q[23:5] <= {pid_in, addr_in, endp_in};
            crc_q          <= CRC_INIT;
            cnt_q          <= 5'd0;
            tok_ready_q    <= 1'b0;
            state_q        <= CRC;
          end
        end
        CRC: begin
          crc_q <= crc_d;
          if (cnt_q == 5'd10) begin
            packet_q[4:0] <= crc_d;
            cnt_q         <= 5'd0;
            tx_valid_q    <= 1'b1;
            tx_bit_q      <= packet_q[23];
            state_q       <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == 5'd23) begin
            cnt_q      <= 5'd0;
            tx_valid_q <= 1'b0;
            tx_bit_q   <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q    <= cnt_q + 5'd1;
            tx_bit_q <= txWindow[22];
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          tok_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tok_ready  = tok_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_bit     = tx_bit_q;
  assign packet_out = packet_q;
  assign done       = done_q;

endmodule

// File: tb/tb_token_tx.sv
// Bench for token_tx: directed and randomized tokens checked cycle by cycle
// against a packet/CRC model derived from the token format rules.
module tb_token_tx;

  logic        clk;
  logic        reset_L;
  logic        tok_valid;
  logic        tok_ready;
  logic [7:0]  pid_in;
  logic [6:0]  addr_in;
  logic [3:0]  endp_in;
  logic        tx_bit;
  logic        tx_valid;
  logic [23:0] packet_out;
  logic        done;

  int checks   = 0;
  int failures = 0;

  token_tx dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .pid_in     (pid_in),
    .addr_in    (addr_in),
    .endp_in    (endp_in),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .packet_out (packet_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] modelCrc(input logic [10:0] data);
    logic [4:0] crc;
    logic       fb;
    crc = 5'b00000;
    for (int i = 10; i >= 0; i--) begin
      fb  = crc[4] ^ data[i];
      crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return crc;
  endfunction

  function automatic logic [23:0] modelPacket(input logic [7:0] p, input logic [6:0] a,
                                              input logic [3:0] e);
    return {p, a, e, modelCrc({a, e})};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with tok_ready high.
  task automatic waitReady(input string tag);
    int budget;
    budget = 0;
    while (tok_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) checkOutput({tag, "_ready_timeout"}, 32'(tok_ready), 32'd1);
  endtask

  // One full token: accepted at E0, checked after every edge up to E36.
  task automatic applyStimulus(input string name, input logic [7:0] pid,
                               input logic [6:0] addr, input logic [3:0] endp,
                               input logic [23:0] expPacket, input bit toggle);
    logic [23:0] rx;
    logic        expBit;
    rx = 24'h0;
    waitReady(name);
    tok_valid = 1'b1;
    pid_in    = pid;
    addr_in   = addr;
    endp_in   = endp;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      expBit = (c >= 11 && c <= 34) ? expPacket[34 - c] : 1'b0;
      checkOutput({name, "_ready"}, 32'(tok_ready), 32'(c == 36));
      checkOutput({name, "_txvalid"}, 32'(tx_valid), 32'(c >= 11 && c <= 34));
      checkOutput({name, "_txbit"}, 32'(tx_bit), 32'(expBit));
      checkOutput({name, "_done"}, 32'(done), 32'(c == 35));
      if (c >= 11)
        checkOutput({name, "_packet"}, 32'(packet_out), 32'(expPacket));
      else
        checkOutput({name, "_fields"}, 32'(packet_out[23:5]), 32'(expPacket[23:5]));
      if (tx_valid === 1'b1) rx = {rx[22:0], tx_bit};
      tok_valid = (toggle && c < 36) ? 1'($urandom_range(0, 1)) : 1'b0;
      pid_in    = 8'($urandom);
      addr_in   = 7'($urandom);
      endp_in   = 4'($urandom);
    end
    checkOutput({name, "_rx_pid"}, 32'(rx[23:16]), 32'(pid));
    checkOutput({name, "_rx_addr"}, 32'(rx[15:9]), 32'(addr));
    checkOutput({name, "_rx_endp"}, 32'(rx[8:5]), 32'(endp));
    checkOutput({name, "_rx_crc"}, 32'(rx[4:0]), 32'(modelCrc({addr, endp})));
  endtask

  logic [7:0] pidAt  [0:79];
  logic [6:0] addrAt [0:79];
  logic [3:0] endpAt [0:79];

  initial begin
    logic [7:0]  rp;
    logic [6:0]  ra;
    logic [3:0]  re;
    logic [23:0] captured [0:2];
    int          doneCyc  [0:2];
    int          doneCount;
    int          budget;

    reset_L   = 1'b0;
    tok_valid = 1'b0;
    pid_in    = 8'h0;
    addr_in   = 7'h0;
    endp_in   = 4'h0;
    #12;
    checkOutput("rst_ready", 32'(tok_ready), 32'd1);
    checkOutput("rst_txvalid", 32'(tx_valid), 32'd0);
    checkOutput("rst_txbit", 32'(tx_bit), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_packet", 32'(packet_out), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    @(negedge clk);

    $display("[TB] directed tokens");
    applyStimulus("e1", 8'hE1, 7'h00, 4'h0, 24'hE10000, 1'b0);
    applyStimulus("69", 8'h69, 7'h00, 4'h1, 24'h690025, 1'b1);
    applyStimulus("2d", 8'h2D, 7'h40, 4'h0, 24'h2D801F, 1'b0);

    $display("[TB] random tokens with tok_valid toggling");
    for (int i = 0; i < 5; i++) begin
      rp = 8'($urandom);
      ra = 7'($urandom);
      re = 4'($urandom);
      applyStimulus("rand", rp, ra, re, modelPacket(rp, ra, re), 1'b1);
    end

    $display("[TB] back-to-back with tok_valid held high");
    waitReady("b2b");
    doneCount = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      pidAt[cyc]  = 8'($urandom);
      addrAt[cyc] = 7'($urandom);
      endpAt[cyc] = 4'($urandom);
      tok_valid   = 1'b1;
      pid_in      = pidAt[cyc];
      addr_in     = addrAt[cyc];
      endp_in     = endpAt[cyc];
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (doneCount < 3) begin
          captured[doneCount] = packet_out;
          doneCyc[doneCount]  = cyc;
        end
        doneCount++;
      end
      @(negedge clk);
    end
    tok_valid = 1'b0;
    checkOutput("b2b_count", 32'(doneCount), 32'd2);
    checkOutput("b2b_cyc0", 32'(doneCyc[0]), 32'd35);
    checkOutput("b2b_cyc1", 32'(doneCyc[1]), 32'd72);
    checkOutput("b2b_pkt0", 32'(captured[0]), 32'(modelPacket(pidAt[0], addrAt[0], endpAt[0])));
    checkOutput("b2b_pkt1", 32'(captured[1]), 32'(modelPacket(pidAt[37], addrAt[37], endpAt[37])));
    budget = 0;
    while (done !== 1'b1 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("b2b_third_done", 32'(done), 32'd1);
    checkOutput("b2b_pkt2", 32'(packet_out), 32'(modelPacket(pidAt[74], addrAt[74], endpAt[74])));
    @(negedge clk);
    waitReady("b2b_end");

    $display("[TB] reset during SHIFT");
    tok_valid = 1'b1;
    pid_in    = 8'hA5;
    addr_in   = 7'h2B;
    endp_in   = 4'h7;
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    checkOutput("mid_txvalid_before", 32'(tx_valid), 32'd1);
    #1;
    reset_L = 1'b0;
    #1;
    checkOutput("mid_txvalid", 32'(tx_valid), 32'd0);
    checkOutput("mid_packet", 32'(packet_out), 32'd0);
    checkOutput("mid_ready", 32'(tok_ready), 32'd1);
    checkOutput("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_L   = 1'b1;
    doneCount = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("mid_no_done", 32'(doneCount), 32'd0);
    applyStimulus("after_rst", 8'h5A, 7'h11, 4'h3, modelPacket(8'h5A, 7'h11, 4'h3), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_tx.md
TOKEN_TX -- requirements
Module: token_tx

Interface
REQ-001 Parameter CRC_INIT, default 5'b00000: initial CRC5 register value loaded at token acceptance.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 tok_valid  input  1  token request valid.
REQ-005 tok_ready  output  1  block can accept a token (high only in IDLE).
REQ-006 pid_in  input  8  PID byte to transmit.
REQ-007 addr_in  input  7  device address.
REQ-008 endp_in  input  4  endpoint number.
REQ-009 tx_bit  output  1  serial packet bit, MSB first.
REQ-010 tx_valid  output  1  tx_bit carries a packet bit this cycle.
REQ-011 packet_out  output  24  assembled packet {pid[23:16], addr[15:9], endp[8:5], crc[4:0]}.
REQ-012 done  output  1  one-cycle pulse after the last serial bit.

Function
REQ-013 The FSM SHALL have the states IDLE, CRC, SHIFT and DONE, one-hot or binary, with no other reachable states.
REQ-014 IDLE: tok_ready=1; on a clock edge with tok_valid=1, the block SHALL latch pid/addr/endp into packet_out[23:5], load crc=CRC_INIT, clear the bit counter, and go to CRC.
REQ-015 CRC: the block SHALL process one data bit per cycle, packet_out[15] down to packet_out[5] (11 cycles), per step fb=crc[4]^bit and crc={crc[3:0],1'b0}^(fb?5'b00101:5'b0) (polynomial x^5+x^2+1), with no final inversion.
REQ-016 On the 11th CRC edge the block SHALL write crc into packet_out[4:0], clear the counter and go to SHIFT.
REQ-017 SHIFT: tx_valid=1 and tx_bit=packet_out[23-k] for k=0..23, one bit per cycle; after k=23 the block SHALL go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 Latency: with acceptance at edge E0, tx_valid is high from E11 through E35 (24 cycles), done is high between E35 and E36, and tok_ready is high again after E36.
REQ-020 tok_valid and all data inputs SHALL be ignored outside IDLE; input changes after acceptance do not affect the packet.
REQ-021 tok_valid held high continuously SHALL produce back-to-back packets, each accepted on the first IDLE cycle.
REQ-022 packet_out SHALL hold its value from the end of CRC until the next acceptance; packet_out[4:0] is undefined-free (holds the previous value) during CRC.
REQ-023 tx_bit SHALL be 0 whenever tx_valid=0.
REQ-024 The bit counter SHALL be 5 bits wide and SHALL never wrap within a state; terminal counts are 10 (CRC) and 23 (SHIFT).

Reset
REQ-025 With reset_L=0, the block SHALL immediately, independent of clk, enter IDLE and set tok_ready=1, tx_valid=0, tx_bit=0, done=0, packet_out=24'h0, crc=5'b0 and counter=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet with no done pulse; after release, the first tok_valid edge starts a fresh packet.

Verification
REQ-027 pid=8'hE1, addr=7'h00, endp=4'h0 -> packet_out=24'hE10000 (crc 5'h00); serial 11100001 followed by 16 zeros; done high at E35-E36.
REQ-028 pid=8'h69, addr=7'h00, endp=4'h1 -> crc=5'h05, packet_out=24'h690025.
REQ-029 pid=8'h2D, addr=7'h40, endp=4'h0 -> crc=5'h1F, packet_out=24'h2D801F; loop the stream into the receive-side token decoder -> no CRC error, fields match.
REQ-030 tok_valid held high for 80 cycles with inputs changing every cycle -> exactly 2 packets of 37 cycles each, each carrying the inputs sampled at its acceptance edge.
REQ-031 reset_L pulsed low at bit k=10 of SHIFT -> tx_valid=0 and packet_out=0 immediately, no done pulse; the next request completes normally.
REQ-032 tok_valid toggled during CRC/SHIFT -> ignored, packet unchanged, tok_ready=0 throughout.
